projectile_pool: RTL and testbench

PROJECTILE_POOL -- requirements
Module: projectile_pool

---
 rtl/game_pkg.sv | 19 +
 rtl/pool_prio_enc.sv | 23 ++
 rtl/projectile_pool.sv | 165 ++++++++++++++++
 tb/tb_projectile_pool.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-wide constants and small helpers used by the sprite/projectile blocks.
package game_pkg;

  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pool_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request plus a found flag.
module pool_prio_enc #(
  parameter int unsigned N = 8,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top down so the lowest asserted bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        idx   = W'(i - 1);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/projectile_pool.sv
// Fixed pool of upward-moving projectiles: edge-triggered launch with cooldown,
// per-tick motion, target collision with a held hit report, and pixel coverage.
module projectile_pool #(
  parameter int unsigned NUM_SLOTS      = 8,
  parameter int unsigned X_W            = game_pkg::X_W,
  parameter int unsigned Y_W            = game_pkg::Y_W,
  parameter int unsigned STEP           = 5,
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned COOLDOWN_TICKS = 4,
  parameter int unsigned X_OFFSET       = 8,
  parameter int unsigned PROJ_W         = 4,
  parameter int unsigned PROJ_H         = 8,
  parameter int unsigned TGT_SIZE       = 32,
  parameter int unsigned IDX_W          = game_pkg::IDX_W
) (
  input  logic                           iVGA_CLK,
  input  logic                           iRST_n,
  input  logic                           fire,
  input  logic                           pause,
  input  logic [X_W-1:0]                 origin_x,
  input  logic [Y_W-1:0]                 origin_y,
  input  logic                           tgt_valid,
  input  logic [IDX_W-1:0]               tgt_idx,
  input  logic [X_W-1:0]                 tgt_x,
  input  logic [Y_W-1:0]                 tgt_y,
  output logic                           tgt_ready,
  output logic                           hit_valid,
  output logic [IDX_W-1:0]               hit_tgt,
  input  logic                           hit_ready,
  input  logic [X_W-1:0]                 pix_x,
  input  logic [Y_W-1:0]                 pix_y,
  output logic                           pix_hit,
  output logic [NUM_SLOTS-1:0]           active_mask,
  output logic [$clog2(NUM_SLOTS+1)-1:0] active_count
);

  localparam int unsigned SW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned PW  = $clog2(TICK_DIV);
  localparam int unsigned CDW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam int unsigned CW  = $clog2(NUM_SLOTS + 1);
  localparam int unsigned XE  = X_W + 1;
  localparam int unsigned YE  = Y_W + 1;

  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [XE-1:0]  TGT_SPAN_X = XE'(TGT_SIZE);
  localparam logic [YE-1:0]  TGT_SPAN_Y = YE'(TGT_SIZE);
  localparam logic [XE-1:0]  PRJ_SPAN_X = XE'(PROJ_W);
  localparam logic [YE-1:0]  PRJ_SPAN_Y = YE'(PROJ_H);
  localparam logic [Y_W-1:0] STEP_Y     = Y_W'(STEP);

  logic [X_W-1:0]       slot_x [NUM_SLOTS];
  logic [Y_W-1:0]       slot_y [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_act;
  logic [PW-1:0]        presc;
  logic [CDW-1:0]       cooldown;
  logic                 fire_q;

  logic                 tick;
  logic                 launch;
  logic                 hit_take;
  logic [NUM_SLOTS-1:0] free_req;
  logic [NUM_SLOTS-1:0] hit_match;
  logic [NUM_SLOTS-1:0] pix_cover;
  logic [SW-1:0]        free_idx;
  logic [SW-1:0]        hit_idx;
  logic                 free_found;
  logic                 hit_found;
  logic [X_W-1:0]       launch_x;

  assign tick         = ~pause && (presc == PRESC_LAST);
  assign tgt_ready    = ~hit_valid;
  assign hit_take     = tgt_valid & ~hit_valid;
  assign launch       = fire & ~fire_q & (cooldown == '0) & ~pause & free_found;
  assign launch_x     = origin_x + X_W'(X_OFFSET);
  assign free_req     = ~slot_act;
  assign active_mask  = slot_act;
  assign active_count = CW'(game_pkg::popcount32(32'(slot_act)));

  // Box tests are done one bit wider than the coordinates so edges near the
  // top of the coordinate range cannot wrap.
  always_comb begin
    hit_match = '0;
    pix_cover = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      hit_match[i] = slot_act[i]
        && ({1'b0, slot_x[i]} >= {1'b0, tgt_x})
        && ({1'b0, slot_x[i]} <  ({1'b0, tgt_x} + TGT_SPAN_X))
        && ({1'b0, slot_y[i]} >= {1'b0, tgt_y})
        && ({1'b0, slot_y[i]} <  ({1'b0, tgt_y} + TGT_SPAN_Y));
      pix_cover[i] = slot_act[i]
        && ({1'b0, pix_x} >= {1'b0, slot_x[i]})
        && ({1'b0, pix_x} <  ({1'b0, slot_x[i]} + PRJ_SPAN_X))
        && ({1'b0, pix_y} >= {1'b0, slot_y[i]})
        && ({1'b0, pix_y} <  ({1'b0, slot_y[i]} + PRJ_SPAN_Y));
    end
  end

  pool_prio_enc #(.N(NUM_SLOTS), .W(SW)) u_free_enc (
    .req   (free_req),
    .idx   (free_idx),
    .found (free_found)
  );

  pool_prio_enc #(.N(NUM_SLOTS), .W(SW)) u_hit_enc (
    .req   (hit_match),
    .idx   (hit_idx),
    .found (hit_found)
  );

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
      slot_act  <= '0;
      presc     <= '0;
      cooldown  <= '0;
      fire_q    <= 1'b1;
      hit_valid <= 1'b0;
      hit_tgt   <= '0;
      pix_hit   <= 1'b0;
    end else begin
      fire_q  <= fire;
      pix_hit <= |pix_cover;

      if (!pause) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      end

      if (launch) begin
        cooldown <= CDW'(COOLDOWN_TICKS);
      end else if (tick && (cooldown != '0)) begin
        cooldown <= cooldown - 1'b1;
      end

      if (hit_valid) begin
        if (hit_ready) begin
          hit_valid <= 1'b0;
        end
      end else if (hit_take && hit_found) begin
        hit_valid <= 1'b1;
        hit_tgt   <= tgt_idx;
      end

      // The launch slot is inactive this cycle, so it never overlaps a hit or a move.
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (hit_take && hit_found && (hit_idx == SW'(i))) begin
          slot_act[i] <= 1'b0;
        end else if (launch && (free_idx == SW'(i))) begin
          slot_act[i] <= 1'b1;
          slot_x[i]   <= launch_x;
          slot_y[i]   <= origin_y;
        end else if (tick && slot_act[i]) begin
          if (slot_y[i] >= STEP_Y) begin
            slot_y[i] <= slot_y[i] - STEP_Y;
          end else begin
            slot_act[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Randomized and directed checks of projectile_pool against a slot-list reference model.
module tb_projectile_pool;

  localparam int NS  = 8;
  localparam int TD  = 4;
  localparam int CD  = 2;
  localparam int STP = 5;
  localparam int XOF = 8;
  localparam int PJW = 4;
  localparam int PJH = 8;
  localparam int TS  = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fire = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] origin_x = '0;
  logic [8:0] origin_y = '0;
  logic       tgt_valid = 1'b0;
  logic [3:0] tgt_idx = '0;
  logic [9:0] tgt_x = '0;
  logic [8:0] tgt_y = '0;
  logic       tgt_ready;
  logic       hit_valid;
  logic [3:0] hit_tgt;
  logic       hit_ready = 1'b0;
  logic [9:0] pix_x = '0;
  logic [8:0] pix_y = '0;
  logic       pix_hit;
  logic [7:0] active_mask;
  logic [3:0] active_count;

  int total = 0;
  int bad   = 0;

  bit m_act [NS];
  int m_x [NS];
  int m_y [NS];
  int m_presc, m_cd, m_ticks, m_ht;
  bit m_fireq, m_hv, m_pix;

  projectile_pool #(
    .NUM_SLOTS(NS), .X_W(10), .Y_W(9), .STEP(STP), .TICK_DIV(TD),
    .COOLDOWN_TICKS(CD), .X_OFFSET(XOF), .PROJ_W(PJW), .PROJ_H(PJH),
    .TGT_SIZE(TS), .IDX_W(4)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .fire(fire), .pause(pause),
    .origin_x(origin_x), .origin_y(origin_y),
    .tgt_valid(tgt_valid), .tgt_idx(tgt_idx), .tgt_x(tgt_x), .tgt_y(tgt_y),
    .tgt_ready(tgt_ready), .hit_valid(hit_valid), .hit_tgt(hit_tgt),
    .hit_ready(hit_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_hit(pix_hit),
    .active_mask(active_mask), .active_count(active_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [7:0] m_mask();
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) r[i] = m_act[i];
    return r;
  endfunction

  function automatic int m_count();
    int n;
    n = 0;
    for (int i = 0; i < NS; i++) n += m_act[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
    end
    m_presc = 0; m_cd = 0; m_ht = 0;
    m_fireq = 1'b1; m_hv = 1'b0; m_pix = 1'b0;
  endtask

  // Advance the model by the rules for one clock using the currently driven inputs.
  task automatic model_step();
    bit tick, lau, pv;
    int hs, fs;
    tick = !pause && (m_presc == TD - 1);
    hs = -1;
    if (tgt_valid && !m_hv) begin
      for (int i = 0; i < NS; i++) begin
        if (hs < 0 && m_act[i] && int'(tgt_x) <= m_x[i] && m_x[i] < int'(tgt_x) + TS &&
            int'(tgt_y) <= m_y[i] && m_y[i] < int'(tgt_y) + TS) hs = i;
      end
    end
    fs = -1;
    for (int i = 0; i < NS; i++) if (fs < 0 && !m_act[i]) fs = i;
    lau = fire && !m_fireq && m_cd == 0 && !pause && fs >= 0;
    pv = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] && m_x[i] <= int'(pix_x) && int'(pix_x) < m_x[i] + PJW &&
          m_y[i] <= int'(pix_y) && int'(pix_y) < m_y[i] + PJH) pv = 1'b1;
    end
    for (int i = 0; i < NS; i++) begin
      if (i == hs) m_act[i] = 1'b0;
      else if (lau && i == fs) begin
        m_act[i] = 1'b1; m_x[i] = (int'(origin_x) + XOF) % 1024; m_y[i] = int'(origin_y);
      end else if (tick && m_act[i]) begin
        if (m_y[i] >= STP) m_y[i] -= STP;
        else m_act[i] = 1'b0;
      end
    end
    if (m_hv) begin
      if (hit_ready) m_hv = 1'b0;
    end else if (hs >= 0) begin
      m_hv = 1'b1; m_ht = int'(tgt_idx);
    end
    m_pix = pv;
    if (lau) m_cd = CD;
    else if (tick && m_cd > 0) m_cd--;
    if (!pause) m_presc = (m_presc == TD - 1) ? 0 : m_presc + 1;
    m_fireq = fire;
    if (tick) m_ticks++;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pause = 1'b0; tgt_valid = 1'b0; hit_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fire = 1'b0;
    do_reset();
    total++; if (active_mask !== 8'h00) begin bad++; $display("FAIL reset_mask got=%h exp=00", active_mask); end
    total++; if (active_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", active_count); end
    total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL reset_hit_valid got=%b exp=0", hit_valid); end
    total++; if (hit_tgt !== 4'd0) begin bad++; $display("FAIL reset_hit_tgt got=%0d exp=0", hit_tgt); end
    total++; if (pix_hit !== 1'b0) begin bad++; $display("FAIL reset_pix_hit got=%b exp=0", pix_hit); end
    total++; if (tgt_ready !== 1'b1) begin bad++; $display("FAIL reset_tgt_ready got=%b exp=1", tgt_ready); end
  endtask

  task automatic test_launch_move();
    int t0;
    fire = 1'b0; do_reset();
    origin_x = 10'd320; origin_y = 9'd450;
    cyc(); fire = 1'b1; cyc(); fire = 1'b0;
    total++; if (active_mask !== 8'h01) begin bad++; $display("FAIL launch_mask got=%h exp=01", active_mask); end
    t0 = m_ticks;
    for (int n = 0; n < 40 && m_ticks < t0 + 4; n++) begin
      cyc();
      total++; if (active_mask !== m_mask()) begin bad++; $display("FAIL move_mask got=%h exp=%h", active_mask, m_mask()); end
    end
    if (m_ticks != t0 + 4) begin total++; bad++; $display("FAIL move_tick_budget got=%0d exp=%0d", m_ticks - t0, 4); end
    pause = 1'b1;
    pix_x = 10'd329; pix_y = 9'd433; cyc();
    total++; if (pix_hit !== 1'b1) begin bad++; $display("FAIL pix_329_433 got=%b exp=1", pix_hit); end
    pix_y = 9'd429; cyc();
    total++; if (pix_hit !== 1'b0) begin bad++; $display("FAIL pix_above_top got=%b exp=0", pix_hit); end
    pix_x = 10'd331; pix_y = 9'd437; cyc();
    total++; if (pix_hit !== 1'b1) begin bad++; $display("FAIL pix_corner got=%b exp=1", pix_hit); end
    pix_x = 10'd332; cyc();
    total++; if (pix_hit !== 1'b0) begin bad++; $display("FAIL pix_right_edge got=%b exp=0", pix_hit); end
    pause = 1'b0;
  endtask

  task automatic test_fire_hold();
    int launches, last_t;
    logic [7:0] prev, nbits;
    origin_x = 10'd320; origin_y = 9'd450;
    fire = 1'b1; do_reset();
    repeat (8) cyc();
    total++; if (active_count !== 4'd0) begin bad++; $display("FAIL fire_across_reset got=%0d exp=0", active_count); end
    fire = 1'b0; cyc(); fire = 1'b1;
    for (int n = 0; n < 80; n++) cyc();
    total++; if (active_count !== 4'd1) begin bad++; $display("FAIL fire_held_count got=%0d exp=1", active_count); end
    fire = 1'b0; do_reset();
    launches = 0; last_t = 0; prev = '0;
    for (int n = 0; n < 200; n++) begin
      fire = ~fire; cyc();
      total++; if (active_mask !== m_mask()) begin bad++; $display("FAIL toggle_mask got=%h exp=%h", active_mask, m_mask()); end
      nbits = active_mask & ~prev;
      if (nbits != 8'h00) begin
        if (launches > 0) begin
          total++; if (m_ticks - last_t < 2) begin bad++; $display("FAIL launch_spacing got=%0d exp>=2", m_ticks - last_t); end
        end
        launches++; last_t = m_ticks;
      end
      prev = active_mask;
    end
    fire = 1'b0;
    total++; if (active_count !== 4'd8) begin bad++; $display("FAIL pool_full_count got=%0d exp=8", active_count); end
    total++; if (launches != 8) begin bad++; $display("FAIL ninth_dropped got=%0d exp=8", launches); end
  endtask

  task automatic test_expire();
    int t0;
    fire = 1'b0; do_reset();
    origin_x = 10'd50; origin_y = 9'd3;
    cyc(); fire = 1'b1; cyc(); fire = 1'b0;
    total++; if (active_count !== 4'd1) begin bad++; $display("FAIL expire_launch got=%0d exp=1", active_count); end
    t0 = m_ticks;
    for (int n = 0; n < 10 && m_ticks == t0; n++) cyc();
    total++; if (active_count !== 4'd0) begin bad++; $display("FAIL expire_count got=%0d exp=0", active_count); end
    pix_x = 10'd58; pix_y = 9'd510; cyc();
    total++; if (pix_hit !== 1'b0) begin bad++; $display("FAIL expire_nowrap got=%b exp=0", pix_hit); end
    do_reset();
    origin_y = 9'd5;
    cyc(); fire = 1'b1; cyc(); fire = 1'b0;
    t0 = m_ticks;
    for (int n = 0; n < 10 && m_ticks == t0; n++) cyc();
    pix_x = 10'd58; pix_y = 9'd0; cyc();
    total++; if (pix_hit !== 1'b1) begin bad++; $display("FAIL y_at_zero_pix got=%b exp=1", pix_hit); end
    total++; if (active_count !== 4'd1) begin bad++; $display("FAIL y_at_zero_count got=%0d exp=1", active_count); end
    t0 = m_ticks;
    for (int n = 0; n < 10 && m_ticks == t0; n++) cyc();
    total++; if (active_count !== 4'd0) begin bad++; $display("FAIL y_zero_expire got=%0d exp=0", active_count); end
  endtask

  task automatic test_collision();
    fire = 1'b0; do_reset();
    origin_x = 10'd300; origin_y = 9'd445;
    for (int n = 0; n < 60 && active_count != 4'd2; n++) begin fire = ~fire; cyc(); end
    fire = 1'b0; pause = 1'b1;
    total++; if (active_mask !== 8'h03) begin bad++; $display("FAIL coll_setup got=%h exp=03", active_mask); end
    tgt_valid = 1'b1; tgt_idx = 4'd7; tgt_x = 10'd300; tgt_y = 9'd420; hit_ready = 1'b0;
    cyc();
    total++; if (hit_valid !== 1'b1) begin bad++; $display("FAIL coll_hit_valid got=%b exp=1", hit_valid); end
    total++; if (hit_tgt !== 4'd7) begin bad++; $display("FAIL coll_hit_tgt got=%0d exp=7", hit_tgt); end
    total++; if (active_mask !== 8'h02) begin bad++; $display("FAIL coll_lowest_cleared got=%h exp=02", active_mask); end
    tgt_idx = 4'd3;
    for (int n = 0; n < 3; n++) begin
      cyc();
      total++; if (hit_valid !== 1'b1 || hit_tgt !== 4'd7) begin bad++; $display("FAIL coll_hold got=%b/%0d exp=1/7", hit_valid, hit_tgt); end
      total++; if (tgt_ready !== 1'b0) begin bad++; $display("FAIL coll_tgt_ready got=%b exp=0", tgt_ready); end
      total++; if (active_mask !== 8'h02) begin bad++; $display("FAIL coll_ignored got=%h exp=02", active_mask); end
    end
    tgt_valid = 1'b0; hit_ready = 1'b1; cyc();
    total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL coll_release got=%b exp=0", hit_valid); end
    hit_ready = 1'b0; tgt_valid = 1'b1; cyc();
    total++; if (hit_tgt !== 4'd3 || active_mask !== 8'h00) begin bad++; $display("FAIL coll_second got=%0d/%h exp=3/00", hit_tgt, active_mask); end
    tgt_valid = 1'b0; hit_ready = 1'b1; cyc();
    tgt_valid = 1'b1; hit_ready = 1'b0; cyc();
    total++; if (hit_valid !== 1'b0) begin bad++; $display("FAIL coll_no_match got=%b exp=0", hit_valid); end
    tgt_valid = 1'b0; pause = 1'b0;
  endtask

  task automatic test_pause_reset();
    fire = 1'b0; do_reset();
    origin_x = 10'd100; origin_y = 9'd200;
    cyc(); fire = 1'b1; cyc(); pause = 1'b1;
    for (int n = 0; n < 20; n++) begin fire = ~fire; cyc(); end
    fire = 1'b0;
    total++; if (active_count !== 4'd1) begin bad++; $display("FAIL pause_count got=%0d exp=1", active_count); end
    pix_x = 10'd108; pix_y = 9'd200; cyc();
    total++; if (pix_hit !== 1'b1) begin bad++; $display("FAIL pause_pos got=%b exp=1", pix_hit); end
    pix_y = 9'd199; cyc();
    total++; if (pix_hit !== 1'b0) begin bad++; $display("FAIL pause_no_move got=%b exp=0", pix_hit); end
    pix_y = 9'd200;
    tgt_valid = 1'b1; tgt_idx = 4'd5; tgt_x = 10'd100; tgt_y = 9'd190; hit_ready = 1'b0;
    cyc();
    tgt_valid = 1'b0;
    total++; if (hit_valid !== 1'b1 || hit_tgt !== 4'd5 || pix_hit !== 1'b1) begin bad++;
      $display("FAIL pause_collision got=%b/%0d/%b exp=1/5/1", hit_valid, hit_tgt, pix_hit); end
    rst_n = 1'b0;
    #1;
    total++; if (hit_valid !== 1'b0 || hit_tgt !== 4'd0 || pix_hit !== 1'b0 || active_mask !== 8'h00 || active_count !== 4'd0) begin bad++;
      $display("FAIL async_reset got=%b/%0d/%b/%h/%0d exp=0/0/0/00/0", hit_valid, hit_tgt, pix_hit, active_mask, active_count); end
    model_reset();
    pause = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int i, tx, ty, px, py;
    fire = 1'b0; do_reset();
    origin_x = 10'd320; origin_y = 9'd400;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 99) < 4) begin
        origin_x = ($urandom_range(0, 3) == 0) ? 10'd1020 : 10'($urandom_range(0, 639));
        origin_y = 9'($urandom_range(0, 479));
      end
      fire = 1'($urandom_range(0, 1));
      pause = ($urandom_range(0, 19) == 0);
      hit_ready = 1'($urandom_range(0, 1));
      tgt_valid = ($urandom_range(0, 9) < 3);
      tgt_idx = 4'($urandom_range(0, 15));
      i = int'($urandom_range(0, NS - 1));
      if (m_act[i]) begin
        tx = m_x[i] - int'($urandom_range(0, 40)); ty = m_y[i] - int'($urandom_range(0, 40));
        px = m_x[i] + int'($urandom_range(0, 6)) - 1; py = m_y[i] + int'($urandom_range(0, 10)) - 1;
      end else begin
        tx = int'($urandom_range(0, 1023)); ty = int'($urandom_range(0, 511));
        px = int'($urandom_range(0, 1023)); py = int'($urandom_range(0, 511));
      end
      tx = (tx < 0) ? 0 : (tx > 1023 ? 1023 : tx);
      ty = (ty < 0) ? 0 : (ty > 511 ? 511 : ty);
      px = (px < 0) ? 0 : (px > 1023 ? 1023 : px);
      py = (py < 0) ? 0 : (py > 511 ? 511 : py);
      tgt_x = 10'(tx); tgt_y = 9'(ty); pix_x = 10'(px); pix_y = 9'(py);
      cyc();
      total++; if (active_mask !== m_mask()) begin bad++; $display("FAIL rnd_mask n=%0d got=%h exp=%h", n, active_mask, m_mask()); end
      total++; if (active_count !== 4'(m_count())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, active_count, m_count()); end
      total++; if (hit_valid !== m_hv) begin bad++; $display("FAIL rnd_hit_valid n=%0d got=%b exp=%b", n, hit_valid, m_hv); end
      total++; if (hit_tgt !== 4'(m_ht)) begin bad++; $display("FAIL rnd_hit_tgt n=%0d got=%0d exp=%0d", n, hit_tgt, m_ht); end
      total++; if (tgt_ready !== !m_hv) begin bad++; $display("FAIL rnd_tgt_ready n=%0d got=%b exp=%b", n, tgt_ready, !m_hv); end
      total++; if (pix_hit !== m_pix) begin bad++; $display("FAIL rnd_pix_hit n=%0d got=%b exp=%b", n, pix_hit, m_pix); end
    end
    fire = 1'b0; pause = 1'b0; tgt_valid = 1'b0;
  endtask

  initial begin
    m_ticks = 0;
    model_reset();
    test_reset();
    test_launch_move();
    test_fire_hold();
    test_expire();
    test_collision();
    test_pause_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
